cam_capture: RTL and testbench

- Upstream stage of the line-buffer memory interface. Converts the OV7670 RGB444 byte stream into 12-bit pixels.
- Frames capture on VSYNC and qualifies pixels with HREF.
- Pushes pixels into the input pixel FIFO that the memory interface drains one 640-pixel line at a time.
- Guards against overflow and malformed lines, and reports frame completion and sticky error status.

---
 rtl/cam_capture.sv | 124 ++++++++++++
 tb/tb_cam_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels and pushes them to the line FIFO.
// Frames open and close on VSYNC rising edges; lines are bounded by HREF and checked for size.
module cam_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic        o_wr,
  output logic [11:0] o_wdata,
  input  logic        i_full,
  output logic        o_frame_done,
  output logic        o_overflow,
  output logic        o_line_err,
  output logic [8:0]  o_line_cnt,
  output logic        o_busy
);

  localparam int PW = $clog2(H_ACTIVE + 2);
  localparam logic [PW-1:0] H_MAX = PW'(H_ACTIVE);
  localparam logic [PW-1:0] H_SAT = PW'(H_ACTIVE + 1);
  localparam logic [8:0]    V_MAX = 9'(V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE} state_t;

  state_t        r_state, w_next;
  logic          r_vsync_q, r_href_q, r_phase;
  logic [3:0]    r_red;
  logic [PW-1:0] r_pix_cnt;
  logic [8:0]    r_line_cnt;
  logic          r_wr, r_frame_done, r_overflow, r_line_err;
  logic [11:0]   r_wdata;

  logic w_vs_rise, w_active, w_byte_vld, w_pix_vld, w_in_range, w_href_fall;
  logic w_frame_start, w_frame_end, w_do_wr, w_ovf_set, w_lerr_set;

  function automatic logic [PW-1:0] sat_inc_pix(input logic [PW-1:0] v);
    return (v >= H_SAT) ? H_SAT : v + 1'b1;
  endfunction

  function automatic logic [8:0] sat_inc_line(input logic [8:0] v);
    return (v >= V_MAX) ? V_MAX : v + 1'b1;
  endfunction

  assign w_vs_rise     = i_vsync & ~r_vsync_q;
  assign w_active      = (r_state == S_ACTIVE);
  assign w_byte_vld    = w_active & i_href & ~i_vsync;
  assign w_pix_vld     = w_byte_vld & r_phase;
  assign w_in_range    = (r_pix_cnt < H_MAX) && (r_line_cnt < V_MAX);
  assign w_href_fall   = w_active & r_href_q & ~i_href;
  assign w_frame_start = (r_state == S_WAIT_VS) & w_vs_rise;
  assign w_frame_end   = w_active & w_vs_rise;
  assign w_do_wr       = w_pix_vld & w_in_range & ~i_full;
  // Only pixels that would otherwise have been written count as overflow drops.
  assign w_ovf_set     = w_pix_vld & w_in_range & i_full;
  assign w_lerr_set    = (w_href_fall & ((r_pix_cnt != H_MAX) | r_phase)) |
                         (w_frame_end & (r_line_cnt != V_MAX));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_en) w_next = S_WAIT_VS;
      S_WAIT_VS: if (w_vs_rise) w_next = S_ACTIVE;
      S_ACTIVE:  if (w_vs_rise) w_next = i_en ? S_ACTIVE : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_vsync_q    <= 1'b0;
      r_href_q     <= 1'b0;
      r_phase      <= 1'b0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_vsync_q    <= i_vsync;
      r_href_q     <= i_href;
      r_wr         <= w_do_wr;
      r_frame_done <= w_frame_end;
      r_overflow   <= (r_overflow & ~i_clr) | w_ovf_set;
      r_line_err   <= (r_line_err & ~i_clr) | w_lerr_set;
      if (w_do_wr) r_wdata <= {r_red, i_data};
      // Frame boundaries take priority over line and byte bookkeeping.
      if (w_frame_start || w_frame_end) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_phase    <= 1'b0;
      end else if (w_href_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= sat_inc_line(r_line_cnt);
        r_phase    <= 1'b0;
      end else if (w_byte_vld) begin
        r_phase <= ~r_phase;
        if (r_phase) r_pix_cnt <= sat_inc_pix(r_pix_cnt);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_byte_vld && !r_phase) r_red <= i_data[3:0];
  end

  assign o_wr         = r_wr;
  assign o_wdata      = r_wdata;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_line_err   = r_line_err;
  assign o_line_cnt   = r_line_cnt;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture using a reduced 8x4 frame geometry.
module tb_cam_capture;

  localparam int H = 8;
  localparam int V = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_en, i_clr, i_vsync, i_href, i_full;
  logic [7:0]  i_data;
  logic        o_wr, o_frame_done, o_overflow, o_line_err, o_busy;
  logic [11:0] o_wdata;
  logic [8:0]  o_line_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int n_wr   = 0;
  int n_abc  = 0;
  int n_fd   = 0;
  int base_wr, base_fd;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr),
    .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
    .o_wr(o_wr), .o_wdata(o_wdata), .i_full(i_full),
    .o_frame_done(o_frame_done), .o_overflow(o_overflow),
    .o_line_err(o_line_err), .o_line_cnt(o_line_cnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr) begin
      n_wr++;
      if (o_wdata == 12'hABC) n_abc++;
    end
    if (o_frame_done) n_fd++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic put(input logic href, input logic [7:0] d);
    i_href = href;
    i_data = d;
    tick();
  endtask

  task automatic vs_pulse();
    i_href  = 1'b0;
    i_vsync = 1'b1;
    tick(); tick();
    i_vsync = 1'b0;
    tick(); tick();
  endtask

  task automatic send_line(input int npix, input bit extra, input int fs, input int fn,
                           input bit special);
    for (int p = 0; p < npix; p++) begin
      if (special && p == 0) begin
        put(1'b1, 8'hF5);
        put(1'b1, 8'h3C);
        check_eq("latency_wr", {31'd0, o_wr}, 32'd1);
        check_eq("latency_wdata", {20'd0, o_wdata}, 32'h53C);
      end else begin
        put(1'b1, 8'h0A);
        i_full = (p >= fs) && (p < fs + fn);
        put(1'b1, 8'hBC);
        i_full = 1'b0;
      end
    end
    if (extra) put(1'b1, 8'h0A);
    put(1'b0, 8'h00);
    put(1'b0, 8'h00);
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_clr = 1'b0; i_vsync = 1'b0;
    i_href = 1'b0; i_full = 1'b0; i_data = 8'h00;
    tick(); tick(); tick();
    check_eq("rst_wr", {31'd0, o_wr}, 32'd0);
    check_eq("rst_wdata", {20'd0, o_wdata}, 32'd0);
    check_eq("rst_fd", {31'd0, o_frame_done}, 32'd0);
    check_eq("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check_eq("rst_lerr", {31'd0, o_line_err}, 32'd0);
    check_eq("rst_lines", {23'd0, o_line_cnt}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Bytes before the first VSYNC edge must be ignored.
    i_en = 1'b1;
    tick();
    send_line(3, 1'b0, 0, 0, 1'b0);
    check_eq("waitvs_wr", n_wr, 0);
    check_eq("waitvs_busy", {31'd0, o_busy}, 32'd1);

    // Frame 1: clean frame, first pixel exercises latency and nibble packing.
    vs_pulse();
    send_line(H, 1'b0, 0, 0, 1'b1);
    for (int l = 1; l < V; l++) send_line(H, 1'b0, 0, 0, 1'b0);
    check_eq("f1_lines", {23'd0, o_line_cnt}, V);
    check_eq("f1_fd_early", n_fd, 0);
    vs_pulse();
    check_eq("f1_writes", n_wr, H * V);
    check_eq("f1_abc", n_abc, H * V - 1);
    check_eq("f1_fd", n_fd, 1);
    check_eq("f1_ovf", {31'd0, o_overflow}, 32'd0);
    check_eq("f1_lerr", {31'd0, o_line_err}, 32'd0);
    check_eq("f1_lines_clr", {23'd0, o_line_cnt}, 32'd0);

    // Frame 2: FIFO full for 3 pixel slots mid-line.
    base_wr = n_wr;
    send_line(H, 1'b0, 2, 3, 1'b0);
    check_eq("ovf_writes", n_wr - base_wr, H - 3);
    check_eq("ovf_set", {31'd0, o_overflow}, 32'd1);
    pulse_clr();
    check_eq("ovf_clr", {31'd0, o_overflow}, 32'd0);
    for (int l = 1; l < V; l++) send_line(H, 1'b0, 0, 0, 1'b0);
    vs_pulse();
    check_eq("f2_lerr", {31'd0, o_line_err}, 32'd0);
    check_eq("f2_fd", n_fd, 2);

    // Frame 3: one long line, one short line with a stray byte.
    base_wr = n_wr;
    send_line(H + 1, 1'b0, 0, 0, 1'b0);
    check_eq("long_writes", n_wr - base_wr, H);
    check_eq("long_lerr", {31'd0, o_line_err}, 32'd1);
    check_eq("long_lines", {23'd0, o_line_cnt}, 32'd1);
    pulse_clr();
    check_eq("lerr_clr", {31'd0, o_line_err}, 32'd0);
    base_wr = n_wr;
    send_line(H - 1, 1'b1, 0, 0, 1'b0);
    check_eq("short_writes", n_wr - base_wr, H - 1);
    check_eq("short_lerr", {31'd0, o_line_err}, 32'd1);
    check_eq("short_lines", {23'd0, o_line_cnt}, 32'd2);
    pulse_clr();
    for (int l = 2; l < V; l++) send_line(H, 1'b0, 0, 0, 1'b0);
    vs_pulse();
    check_eq("f3_lerr", {31'd0, o_line_err}, 32'd0);
    check_eq("f3_fd", n_fd, 3);

    // Frame 4: reset in the middle of a pixel.
    base_fd = n_fd;
    send_line(H, 1'b0, 0, 0, 1'b0);
    send_line(H, 1'b0, 0, 0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      put(1'b1, 8'h0A);
      put(1'b1, 8'hBC);
    end
    check_eq("pre_rst_lines", {23'd0, o_line_cnt}, 32'd2);
    put(1'b1, 8'h0A);
    i_rst = 1'b1;
    put(1'b1, 8'hBC);
    check_eq("midrst_wr", {31'd0, o_wr}, 32'd0);
    check_eq("midrst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("midrst_lines", {23'd0, o_line_cnt}, 32'd0);
    i_rst = 1'b0;
    i_href = 1'b0;
    tick();
    base_wr = n_wr;
    send_line(H, 1'b0, 0, 0, 1'b0);
    check_eq("postrst_writes", n_wr - base_wr, 0);
    check_eq("midrst_fd", n_fd - base_fd, 0);

    // Frame 5: enable dropped mid-frame; the frame still completes.
    base_wr = n_wr;
    base_fd = n_fd;
    vs_pulse();
    send_line(H, 1'b0, 0, 0, 1'b0);
    send_line(H, 1'b0, 0, 0, 1'b0);
    i_en = 1'b0;
    send_line(H, 1'b0, 0, 0, 1'b0);
    send_line(H, 1'b0, 0, 0, 1'b0);
    check_eq("dis_busy_mid", {31'd0, o_busy}, 32'd1);
    check_eq("dis_lines", {23'd0, o_line_cnt}, V);
    vs_pulse();
    check_eq("dis_writes", n_wr - base_wr, H * V);
    check_eq("dis_fd", n_fd - base_fd, 1);
    check_eq("dis_lerr", {31'd0, o_line_err}, 32'd0);
    check_eq("dis_busy", {31'd0, o_busy}, 32'd0);
    send_line(H, 1'b0, 0, 0, 1'b0);
    vs_pulse();
    check_eq("idle_writes", n_wr - base_wr, H * V);
    check_eq("idle_fd", n_fd - base_fd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
